tm_cpu_retire_track: RTL and testbench
======================================

TM_CPU_RETIRE_TRACK -- requirements
Module: tm_cpu_retire_track

Interface
REQ-001 SHALL have parameter CNTW, default 48: width of each per-thread retired-instruction counter.
REQ-002 SHALL have parameter NT, default NTHREAD: number of tracked threads; TW = NTHREADIDMSB+1.
REQ-003 gclk  in  iu_clk_type  clock; all state SHALL update on the rising edge of gclk.clk.
REQ-004 rst  in  1  reset; SHALL be synchronous, active-high.
REQ-005 run  in  1  timing model running (TM running output).
REQ-006 tick  in  1  TM new-target-cycle pulse.
REQ-007 issue_valid, issue_tid  in  1, TW  token issued by the TM into the pipeline (valid qualified by run).
REQ-008 wb_valid, wb_tid, wb_replay  in  1, TW, 1  IU writeback result: retired (replay=0) or must replay (replay=1).
REQ-009 clr_req  in  1  one-cycle request to zero all counters.
REQ-010 cpu2tm_valid, cpu2tm_replay, cpu2tm_tid  out  1, 1, TW  registered token to the TM.
REQ-011 dbg_tid  in  TW; dbg_cnt  out  CNTW  debug counter read port.
REQ-012 busy  out  1  counter clear sweep in progress.
REQ-013 err_orphan, err_dup, err_reissue  out  1 each  sticky error flags.
REQ-014 inflight_cnt  out  TW+1  number of threads with an instruction in flight.

Function
REQ-015 inflight[NT] bitmap: issue_valid & run SHALL set bit issue_tid; accepted wb_valid SHALL clear bit wb_tid.
REQ-016 Same-cycle issue and wb on the same tid SHALL leave the bit set, no error.
REQ-017 issue to a tid whose bit is set (and not cleared same cycle) SHALL set err_reissue.
REQ-018 wb_valid on a tid with inflight bit clear SHALL set err_orphan and produce no token.
REQ-019 Accepted wb SHALL appear on cpu2tm exactly 1 cycle later: valid = ~wb_replay & run, replay = wb_replay & run, tid = wb_tid; otherwise valid = replay = 0.
REQ-020 retired[NT] bitmap SHALL set bit on accepted retire (replay=0); retire on an already-set bit without same-cycle tick SHALL set err_dup.
REQ-021 On tick, retired SHALL load the one-hot of a same-cycle accepted retire, else all zero (concurrent retire belongs to the new target cycle).
REQ-022 Counters: accepted retire with run=1 and state READY SHALL increment counter[wb_tid] modulo 2^CNTW (max wraps to 0).
REQ-023 Counter update SHALL be read-modify-write over 2 cycles with forwarding so back-to-back retires of the same tid each count.
REQ-024 dbg_cnt SHALL return counter[dbg_tid] 1 cycle after dbg_tid, reflecting all writes committed before the read cycle.
REQ-025 FSM states CLEAR, READY: CLEAR sweeps addr 0..NT-1 writing zero, one per cycle, then READY; busy = (state==CLEAR).
REQ-026 clr_req in READY SHALL enter CLEAR at addr 0; clr_req in CLEAR SHALL restart the sweep at addr 0.
REQ-027 During CLEAR, tokens SHALL still be forwarded and bitmaps maintained; counters SHALL NOT increment.
REQ-028 Rising edge of run SHALL clear inflight, retired and all error flags.
REQ-029 inflight_cnt SHALL be the registered popcount of inflight.

Reset
REQ-030 rst SHALL force: state CLEAR, addr 0, busy 1 next cycle, inflight/retired 0, all errors 0, cpu2tm_valid/replay 0, cpu2tm_tid 0, inflight_cnt 0.
REQ-031 rst asserted mid-sweep or mid-RMW SHALL abandon the operation and restart the sweep; pending increment SHALL be dropped.

Structure
REQ-032 NTHREAD/NTHREADIDMSB SHALL come from libconf; the cpu2tm token type from libtm; a tm_retire_state_type enum SHALL be added to libtm.
REQ-033 Counter storage with RMW forwarding and debug read port SHALL be sub-module tm_retire_cnt_ram (distributed RAM, NT x CNTW).

Verification
REQ-034 Reset, NT=8: busy high exactly 8 cycles; all dbg_cnt reads return 0.
REQ-035 Issue tid 3, wb tid 3 replay=0 at cycle t -> cpu2tm valid=1, tid=3 at t+1; counter[3]=1.
REQ-036 wb tid 5 replay=1 -> cpu2tm replay=1, valid=0; counter[5] unchanged; inflight bit 5 cleared.
REQ-037 Retire tid 2 on 4 consecutive cycles (reissued each cycle) -> counter[2]=4; counter preloaded 2^CNTW-1 wraps to 0.
REQ-038 wb tid 6 with no issue -> err_orphan=1, no token; second retire of tid 1 before tick -> err_dup=1; retire concurrent with tick -> no err_dup.
REQ-039 clr_req during sweep at addr 5 -> sweep restarts at 0, busy for 8 more cycles; retires during sweep forwarded but not counted.

Source files
------------

// File: rtl/tm_cpu_retire_track_pkg.sv
// Shared types for the TM retire tracker: thread config, clock bundle,
// the CPU-to-TM token and the retire-tracker FSM state.
package tm_cpu_retire_track_pkg;

  localparam int NTHREAD      = 8;
  localparam int NTHREADIDMSB = 2;
  localparam int TW           = NTHREADIDMSB + 1;

  typedef struct packed {
    logic clk;
  } iu_clk_type;

  typedef struct packed {
    logic          valid;
    logic          replay;
    logic [TW-1:0] tid;
  } cpu2tm_type;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } tm_retire_state_type;

endpackage

// File: rtl/tm_retire_cnt_ram.sv
// Per-thread retired-instruction counters: distributed RAM with a two-cycle
// read-modify-write increment path, a clear write port and a debug read port.
module tm_retire_cnt_ram
  import tm_cpu_retire_track_pkg::*;
#(
  parameter int NT   = 8,
  parameter int CNTW = 48,
  parameter int AW   = 3
) (
  input  iu_clk_type      gclk,
  input  logic            rst,
  input  logic            clr_we,
  input  logic [AW-1:0]   clr_addr,
  input  logic            inc_req,
  input  logic [AW-1:0]   inc_tid,
  input  logic [AW-1:0]   dbg_tid,
  output logic [CNTW-1:0] dbg_cnt
);

  logic [CNTW-1:0] mem [NT];
  logic            s2_vld;
  logic [AW-1:0]   s2_tid;
  logic [CNTW-1:0] s2_old;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [CNTW-1:0] wdata;

  // Clear sweep owns the single write port; a colliding increment is dropped
  // because the sweep zeroes every entry anyway.
  always_comb begin
    we    = ~rst & (clr_we | s2_vld);
    waddr = clr_we ? clr_addr : s2_tid;
    wdata = clr_we ? '0 : s2_old + CNTW'(1);
  end

  always_ff @(posedge gclk.clk) begin
    if (rst) begin
      s2_vld <= 1'b0;
      s2_tid <= '0;
      s2_old <= '0;
    end else begin
      s2_vld <= inc_req;
      s2_tid <= inc_tid;
      // Forward the in-flight write so back-to-back increments of one tid chain.
      s2_old <= (we && waddr == inc_tid) ? wdata : mem[inc_tid];
    end
  end

  always_ff @(posedge gclk.clk) begin
    if (we) mem[waddr] <= wdata;
    dbg_cnt <= mem[dbg_tid];
  end

endmodule

// File: rtl/tm_cpu_retire_track.sv
// Tracks in-flight and retired instructions per thread, forwards IU writeback
// results to the timing model as tokens and counts retirements per thread.
module tm_cpu_retire_track
  import tm_cpu_retire_track_pkg::*;
#(
  parameter int CNTW = 48,
  parameter int NT   = NTHREAD
) (
  input  iu_clk_type          gclk,
  input  logic                rst,
  input  logic                run,
  input  logic                tick,
  input  logic                issue_valid,
  input  logic [TW-1:0]       issue_tid,
  input  logic                wb_valid,
  input  logic [TW-1:0]       wb_tid,
  input  logic                wb_replay,
  input  logic                clr_req,
  output logic                cpu2tm_valid,
  output logic                cpu2tm_replay,
  output logic [TW-1:0]       cpu2tm_tid,
  input  logic [TW-1:0]       dbg_tid,
  output logic [CNTW-1:0]     dbg_cnt,
  output logic                busy,
  output logic                err_orphan,
  output logic                err_dup,
  output logic                err_reissue,
  output logic [TW:0]         inflight_cnt,
  output tm_retire_state_type dbg_state
);

  // Token semantics: cpu2tm_valid/cpu2tm_replay are single-cycle pulses, one
  // cycle after an accepted writeback; there is no backpressure from the TM.
  tm_retire_state_type state, state_nxt;
  logic [TW-1:0] addr, addr_nxt;
  logic [NT-1:0] inflight, inflight_nxt, retired, retired_nxt;
  logic [NT-1:0] issue_oh, acc_oh, ret_oh;
  logic          run_q, run_rise, issue_go, acc, ret, inc_req;
  logic          set_orphan, set_dup, set_reissue;
  logic [TW:0]   pop_nxt;
  cpu2tm_type    tok;

  always_ff @(posedge gclk.clk) begin
    if (rst) begin
      state <= CLEAR;
      addr  <= '0;
    end else begin
      state <= state_nxt;
      addr  <= addr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    case (state)
      CLEAR: begin
        if (clr_req) addr_nxt = '0;
        else if (addr == TW'(NT - 1)) begin
          state_nxt = READY;
          addr_nxt  = '0;
        end else addr_nxt = addr + TW'(1);
      end
      READY: begin
        if (clr_req) begin
          state_nxt = CLEAR;
          addr_nxt  = '0;
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  always_comb begin
    run_rise    = run & ~run_q;
    issue_go    = issue_valid & run;
    acc         = wb_valid & inflight[wb_tid];
    ret         = acc & ~wb_replay;
    issue_oh    = issue_go ? (NT'(1) << issue_tid) : '0;
    acc_oh      = acc ? (NT'(1) << wb_tid) : '0;
    ret_oh      = ret ? acc_oh : '0;
    set_orphan  = wb_valid & ~inflight[wb_tid];
    set_dup     = ret & retired[wb_tid] & ~tick;
    set_reissue = issue_go & inflight[issue_tid] & ~(acc & (wb_tid == issue_tid));
    inc_req     = ret & run & (state == READY);
    inflight_nxt = ((run_rise ? '0 : inflight) & ~acc_oh) | issue_oh;
    if (run_rise)  retired_nxt = '0;
    else if (tick) retired_nxt = ret_oh;
    else           retired_nxt = retired | ret_oh;
    pop_nxt = '0;
    for (int i = 0; i < NT; i++) pop_nxt = pop_nxt + (TW+1)'(inflight_nxt[i]);
  end

  always_ff @(posedge gclk.clk) begin
    if (rst) begin
      run_q        <= 1'b0;
      inflight     <= '0;
      retired      <= '0;
      err_orphan   <= 1'b0;
      err_dup      <= 1'b0;
      err_reissue  <= 1'b0;
      tok          <= '0;
      inflight_cnt <= '0;
    end else begin
      run_q        <= run;
      inflight     <= inflight_nxt;
      retired      <= retired_nxt;
      err_orphan   <= ~run_rise & (err_orphan | set_orphan);
      err_dup      <= ~run_rise & (err_dup | set_dup);
      err_reissue  <= ~run_rise & (err_reissue | set_reissue);
      tok.valid    <= acc & ~wb_replay & run;
      tok.replay   <= acc & wb_replay & run;
      if (acc) tok.tid <= wb_tid;
      inflight_cnt <= pop_nxt;
    end
  end

  assign cpu2tm_valid  = tok.valid;
  assign cpu2tm_replay = tok.replay;
  assign cpu2tm_tid    = tok.tid;
  assign busy          = (state == CLEAR);
  assign dbg_state     = state;

  tm_retire_cnt_ram #(.NT(NT), .CNTW(CNTW), .AW(TW)) u_cnt_ram (
    .gclk     (gclk),
    .rst      (rst),
    .clr_we   (state == CLEAR),
    .clr_addr (addr),
    .inc_req  (inc_req),
    .inc_tid  (wb_tid),
    .dbg_tid  (dbg_tid),
    .dbg_cnt  (dbg_cnt)
  );

endmodule

// File: tb/tb_tm_cpu_retire_track.sv
// Directed bench for tm_cpu_retire_track with a narrow counter so wrap is reachable.
module tb_tm_cpu_retire_track;
  import tm_cpu_retire_track_pkg::*;

  localparam int CW = 4;

  iu_clk_type          gclk;
  logic                rst, run, tick, issue_valid, wb_valid, wb_replay, clr_req;
  logic [TW-1:0]       issue_tid, wb_tid, dbg_tid, cpu2tm_tid;
  logic                cpu2tm_valid, cpu2tm_replay, busy;
  logic                err_orphan, err_dup, err_reissue;
  logic [CW-1:0]       dbg_cnt;
  logic [TW:0]         inflight_cnt;
  tm_retire_state_type dbg_state;

  int checks = 0;
  int errors = 0;

  tm_cpu_retire_track #(.CNTW(CW), .NT(8)) dut (
    .gclk(gclk), .rst(rst), .run(run), .tick(tick),
    .issue_valid(issue_valid), .issue_tid(issue_tid),
    .wb_valid(wb_valid), .wb_tid(wb_tid), .wb_replay(wb_replay),
    .clr_req(clr_req), .cpu2tm_valid(cpu2tm_valid), .cpu2tm_replay(cpu2tm_replay),
    .cpu2tm_tid(cpu2tm_tid), .dbg_tid(dbg_tid), .dbg_cnt(dbg_cnt), .busy(busy),
    .err_orphan(err_orphan), .err_dup(err_dup), .err_reissue(err_reissue),
    .inflight_cnt(inflight_cnt), .dbg_state(dbg_state)
  );

  initial gclk.clk = 1'b0;
  always #5 gclk.clk = ~gclk.clk;

  task automatic step();
    @(posedge gclk.clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; wb_valid = 0; wb_replay = 0; clr_req = 0; tick = 0;
  endtask

  task automatic read_cnt(input logic [TW-1:0] t, output logic [CW-1:0] v);
    dbg_tid = t;
    step();
    v = dbg_cnt;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    logic [CW-1:0] v;
    idle(); run = 1; rst = 1;
    step(); step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy got %b want 1", busy); end
    checks++; if ({cpu2tm_valid, cpu2tm_replay, cpu2tm_tid} !== 5'b0) begin errors++;
      $display("FAIL rst_token got %b%b%0d want 0", cpu2tm_valid, cpu2tm_replay, cpu2tm_tid); end
    checks++; if ({err_orphan, err_dup, err_reissue} !== 3'b0) begin errors++;
      $display("FAIL rst_errs got %b%b%b want 000", err_orphan, err_dup, err_reissue); end
    checks++; if (inflight_cnt !== '0) begin errors++; $display("FAIL rst_inflight got %0d want 0", inflight_cnt); end
    rst = 0;
    count_busy(n);
    checks++; if (n != 8) begin errors++; $display("FAIL rst_sweep_len got %0d want 8", n); end
    checks++; if (dbg_state !== READY) begin errors++; $display("FAIL rst_state got %0d want READY", dbg_state); end
    for (int t = 0; t < 8; t++) begin
      read_cnt(TW'(t), v);
      checks++; if (v !== '0) begin errors++; $display("FAIL rst_cnt%0d got %0d want 0", t, v); end
    end
  endtask

  task automatic test_retire();
    logic [CW-1:0] v;
    idle(); issue_valid = 1; issue_tid = 3;
    step();
    idle(); wb_valid = 1; wb_tid = 3; wb_replay = 0;
    step();
    checks++; if ({cpu2tm_valid, cpu2tm_replay, cpu2tm_tid} !== {2'b10, 3'd3}) begin errors++;
      $display("FAIL retire_token got v%b r%b t%0d want v1 r0 t3", cpu2tm_valid, cpu2tm_replay, cpu2tm_tid); end
    idle();
    step();
    checks++; if (cpu2tm_valid !== 1'b0) begin errors++; $display("FAIL retire_pulse got %b want 0", cpu2tm_valid); end
    step();
    read_cnt(3, v);
    checks++; if (v !== 4'd1) begin errors++; $display("FAIL retire_cnt3 got %0d want 1", v); end
    checks++; if (inflight_cnt !== '0) begin errors++; $display("FAIL retire_inflight got %0d want 0", inflight_cnt); end
  endtask

  task automatic test_replay();
    logic [CW-1:0] v;
    idle(); issue_valid = 1; issue_tid = 5;
    step();
    idle();
    step();
    checks++; if (inflight_cnt !== 4'd1) begin errors++; $display("FAIL replay_inflight1 got %0d want 1", inflight_cnt); end
    wb_valid = 1; wb_tid = 5; wb_replay = 1;
    step();
    checks++; if ({cpu2tm_valid, cpu2tm_replay, cpu2tm_tid} !== {2'b01, 3'd5}) begin errors++;
      $display("FAIL replay_token got v%b r%b t%0d want v0 r1 t5", cpu2tm_valid, cpu2tm_replay, cpu2tm_tid); end
    idle();
    step(); step();
    checks++; if (inflight_cnt !== '0) begin errors++; $display("FAIL replay_inflight0 got %0d want 0", inflight_cnt); end
    read_cnt(5, v);
    checks++; if (v !== '0) begin errors++; $display("FAIL replay_cnt5 got %0d want 0", v); end
  endtask

  task automatic burst(input logic [TW-1:0] t, input int n);
    idle(); tick = 1; issue_valid = 1; issue_tid = t;
    step();
    for (int i = 0; i < n; i++) begin
      wb_valid = 1; wb_tid = t; wb_replay = 0;
      issue_valid = (i != n - 1);
      step();
      checks++; if (cpu2tm_valid !== 1'b1 || cpu2tm_tid !== t) begin errors++;
        $display("FAIL burst_token tid%0d beat%0d got v%b t%0d", t, i, cpu2tm_valid, cpu2tm_tid); end
    end
    idle();
    step(); step();
  endtask

  task automatic test_back_to_back();
    logic [CW-1:0] v;
    burst(2, 4);
    read_cnt(2, v);
    checks++; if (v !== 4'd4) begin errors++; $display("FAIL b2b_cnt2 got %0d want 4", v); end
    checks++; if ({err_dup, err_reissue} !== 2'b0) begin errors++;
      $display("FAIL b2b_errs got dup%b reissue%b want 00", err_dup, err_reissue); end
    burst(7, 15);
    read_cnt(7, v);
    checks++; if (v !== 4'd15) begin errors++; $display("FAIL wrap_max got %0d want 15", v); end
    burst(7, 1);
    read_cnt(7, v);
    checks++; if (v !== 4'd0) begin errors++; $display("FAIL wrap_zero got %0d want 0", v); end
  endtask

  task automatic retire_once(input logic [TW-1:0] t, input logic tk);
    idle(); issue_valid = 1; issue_tid = t;
    step();
    idle(); wb_valid = 1; wb_tid = t; tick = tk;
    step();
    idle();
  endtask

  task automatic test_errors();
    idle(); wb_valid = 1; wb_tid = 6; wb_replay = 0;
    step();
    idle();
    checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_flag got %b want 1", err_orphan); end
    checks++; if ({cpu2tm_valid, cpu2tm_replay} !== 2'b00) begin errors++;
      $display("FAIL orphan_token got v%b r%b want 00", cpu2tm_valid, cpu2tm_replay); end
    retire_once(1, 0);
    retire_once(1, 0);
    checks++; if (err_dup !== 1'b1) begin errors++; $display("FAIL dup_flag got %b want 1", err_dup); end
    run = 0; step(); run = 1; step();
    checks++; if ({err_orphan, err_dup, err_reissue} !== 3'b0) begin errors++;
      $display("FAIL run_rise_clear got %b%b%b want 000", err_orphan, err_dup, err_reissue); end
    retire_once(1, 0);
    retire_once(1, 1);
    checks++; if (err_dup !== 1'b0) begin errors++; $display("FAIL dup_tick got %b want 0", err_dup); end
    retire_once(1, 0);
    checks++; if (err_dup !== 1'b1) begin errors++; $display("FAIL dup_after_tick got %b want 1", err_dup); end
    issue_valid = 1; issue_tid = 4;
    step();
    checks++; if (err_reissue !== 1'b0) begin errors++; $display("FAIL reissue_early got %b want 0", err_reissue); end
    step();
    idle();
    checks++; if (err_reissue !== 1'b1) begin errors++; $display("FAIL reissue_flag got %b want 1", err_reissue); end
  endtask

  task automatic test_clr_sweep();
    int n;
    logic [CW-1:0] v;
    idle(); run = 1; rst = 1;
    step(); step();
    rst = 0;
    repeat (5) step();
    clr_req = 1;
    step();
    clr_req = 0; issue_valid = 1; issue_tid = 0;
    step();
    idle(); wb_valid = 1; wb_tid = 0;
    step();
    idle();
    checks++; if (cpu2tm_valid !== 1'b1 || cpu2tm_tid !== 3'd0) begin errors++;
      $display("FAIL sweep_token got v%b t%0d want v1 t0", cpu2tm_valid, cpu2tm_tid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sweep_busy got %b want 1", busy); end
    count_busy(n);
    checks++; if (n + 2 != 8) begin errors++; $display("FAIL sweep_restart_len got %0d want 8", n + 2); end
    step();
    read_cnt(0, v);
    checks++; if (v !== '0) begin errors++; $display("FAIL sweep_nocount got %0d want 0", v); end
    read_cnt(3, v);
    checks++; if (v !== '0) begin errors++; $display("FAIL sweep_cleared3 got %0d want 0", v); end
    clr_req = 1;
    step();
    clr_req = 0;
    count_busy(n);
    checks++; if (n != 8) begin errors++; $display("FAIL clr_ready_len got %0d want 8", n); end
  endtask

  initial begin
    rst = 1; run = 0; issue_tid = 0; wb_tid = 0; dbg_tid = 0;
    idle();
    test_reset();
    test_retire();
    test_replay();
    test_back_to_back();
    test_errors();
    test_clr_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end

endmodule
